// File: rtl/core_mem_mux.sv
`default_nettype none
// ============================================================================
// Module   : core_mem_mux
// Purpose  : Funnels arbiter-granted core requests onto one shared memory port,
//            one transaction at a time, and routes the completion back.
// Revision : 1.0 - initial release
// ============================================================================
module core_mem_mux #(
    parameter int NUM_CORES = 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        grant,
    input  logic [NUM_CORES-1:0]        core_req_valid,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    input  logic [NUM_CORES-1:0]        core_we,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_valid,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    input  logic                        mem_ready,
    input  logic                        mem_rsp_valid,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    localparam int OWNER_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [NUM_CORES-1:0] w_req;
    logic                 w_hit;
    logic [OWNER_W-1:0]   w_sel;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic                 w_sel_we;
    logic                 w_capture;
    logic                 w_rsp;
    logic [NUM_CORES-1:0] w_owner_dec;

    logic [OWNER_W-1:0]   r_owner;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_we;
    logic [NUM_CORES-1:0] r_core_ack;
    logic [DATA_W-1:0]    r_rdata;

    // Grants without a pending request are masked out before selection.
    assign w_req = grant & core_req_valid;

    // Descending scan so the lowest set bit is the last (winning) assignment.
    always_comb begin
        w_hit       = 1'b0;
        w_sel       = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_hit       = 1'b1;
                w_sel       = OWNER_W'(i);
                w_sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = core_wdata[i*DATA_W +: DATA_W];
                w_sel_we    = core_we[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            w_owner_dec[i] = (OWNER_W'(i) == r_owner);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_rsp     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_capture = 1'b1;
                    w_next    = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    w_rsp  = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Payload is only ever written in IDLE, so it is stable for the whole ISSUE phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_core_ack <= '0;
            r_rdata    <= '0;
        end else begin
            r_core_ack <= '0;
            if (w_capture) begin
                r_owner <= w_sel;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_we    <= w_sel_we;
            end
            if (w_rsp) begin
                r_core_ack <= w_owner_dec;
                r_rdata    <= mem_rdata;
            end
        end
    end

    assign mem_valid  = (r_state == ISSUE);
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_we     = r_we;
    assign core_ack   = r_core_ack;
    assign core_rdata = r_rdata;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_core_mem_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_mem_mux
// Purpose  : Scoreboard bench for core_mem_mux (4-core and 1-core instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_mem_mux;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } req_t;

    typedef struct {
        logic [3:0]  ack;
        logic [31:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [3:0]   grant, core_req_valid, core_we, core_ack;
    logic [127:0] core_addr, core_wdata;
    logic [31:0]  core_rdata, mem_addr, mem_wdata, mem_rdata;
    logic         mem_valid, mem_we, mem_ready, mem_rsp_valid, busy;

    logic [0:0]   s_grant, s_req, s_we, s_ack;
    logic [31:0]  s_addr, s_wdata, s_rdata, s_mem_addr, s_mem_wdata, s_mrdata;
    logic         s_mem_valid, s_mem_we, s_ready, s_rsp, s_busy;

    int   checks = 0;
    int   errors = 0;
    req_t req_q[$];
    rsp_t exp_q[$];

    core_mem_mux #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .grant(grant), .core_req_valid(core_req_valid),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
        .core_ack(core_ack), .core_rdata(core_rdata), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ready(mem_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    core_mem_mux #(.NUM_CORES(1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .grant(s_grant), .core_req_valid(s_req),
        .core_addr(s_addr), .core_wdata(s_wdata), .core_we(s_we),
        .core_ack(s_ack), .core_rdata(s_rdata), .mem_valid(s_mem_valid),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_we(s_mem_we),
        .mem_ready(s_ready), .mem_rsp_valid(s_rsp), .mem_rdata(s_mrdata),
        .busy(s_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_payloads();
        for (int i = 0; i < 4; i++) begin
            core_addr[i*32 +: 32]  = $urandom;
            core_wdata[i*32 +: 32] = $urandom;
        end
        core_we = 4'($urandom);
    endtask

    // Lowest set bit of grant & request; -1 when none.
    function automatic int exp_owner(input logic [3:0] gnt, input logic [3:0] req);
        logic [3:0] v;
        int o;
        v = gnt & req;
        o = -1;
        for (int i = 3; i >= 0; i--) if (v[i]) o = i;
        return o;
    endfunction

    // One full transaction. started=1 means the grant was already accepted in the previous ack cycle.
    task automatic do_txn(input logic [3:0] gnt, input logic [3:0] req, input logic we,
                          input logic [31:0] rdata, input int stall, input int rsp_dly,
                          input logic [3:0] busy_gnt, input logic [3:0] chain_gnt,
                          input logic [3:0] chain_req, input bit started);
        int   own;
        int   cown;
        req_t e;
        rsp_t r;
        own = exp_owner(gnt, req);
        if (!started) begin
            randomize_payloads();
            core_we[own]   = we;
            core_req_valid = req;
            grant          = gnt;
            req_q.push_back('{core_addr[own*32 +: 32], core_wdata[own*32 +: 32], core_we[own]});
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL pre_grant_busy got %0b exp 0", busy); end
            tick();
        end
        grant = busy_gnt;
        e = req_q.pop_front();
        for (int s = 0; s <= stall; s++) begin
            mem_ready = (s == stall);
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== e.addr || mem_wdata !== e.wdata || mem_we !== e.we) begin
                errors++;
                $display("FAIL issue_payload cyc %0d got v=%0b a=%h d=%h w=%0b exp v=1 a=%h d=%h w=%0b",
                         s, mem_valid, mem_addr, mem_wdata, mem_we, e.addr, e.wdata, e.we);
            end
            tick();
        end
        mem_ready = 1'b0;
        for (int d = 0; d <= rsp_dly; d++) begin
            checks++;
            if (mem_valid !== 1'b0 || busy !== 1'b1 || core_ack !== 4'b0000) begin
                errors++;
                $display("FAIL wait_state got v=%0b busy=%0b ack=%b exp v=0 busy=1 ack=0000",
                         mem_valid, busy, core_ack);
            end
            if (d == rsp_dly) begin
                grant         = 4'b0000;
                mem_rsp_valid = 1'b1;
                mem_rdata     = rdata;
                exp_q.push_back('{4'(1 << own), rdata});
            end
            tick();
        end
        mem_rsp_valid = 1'b0;
        mem_rdata     = $urandom;
        r = exp_q.pop_front();
        checks++;
        if (core_ack !== r.ack || core_rdata !== r.rdata || mem_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_cycle got ack=%b rdata=%h v=%0b busy=%0b exp ack=%b rdata=%h v=0 busy=0",
                     core_ack, core_rdata, mem_valid, busy, r.ack, r.rdata);
        end
        core_req_valid[own] = 1'b0;
        if (chain_gnt != 4'b0000) begin
            cown           = exp_owner(chain_gnt, chain_req);
            core_req_valid = chain_req;
            grant          = chain_gnt;
            req_q.push_back('{core_addr[cown*32 +: 32], core_wdata[cown*32 +: 32], core_we[cown]});
        end
        tick();
        grant = 4'b0000;
        checks++;
        if (core_ack !== 4'b0000 || core_rdata !== r.rdata || busy !== (chain_gnt != 4'b0000)) begin
            errors++;
            $display("FAIL post_ack got ack=%b rdata=%h busy=%0b exp ack=0000 rdata=%h busy=%0b",
                     core_ack, core_rdata, busy, r.rdata, (chain_gnt != 4'b0000));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || mem_valid !== 1'b0 || core_ack !== 4'b0000 || core_rdata !== 32'h0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got busy=%0b v=%0b ack=%b rd=%h a=%h d=%h w=%0b exp all zero",
                     busy, mem_valid, core_ack, core_rdata, mem_addr, mem_wdata, mem_we);
        end
        checks++;
        if (s_busy !== 1'b0 || s_mem_valid !== 1'b0 || s_ack !== 1'b0 || s_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_single got busy=%0b v=%0b ack=%b rd=%h exp all zero",
                     s_busy, s_mem_valid, s_ack, s_rdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_read();
        do_txn(4'b0100, 4'b0100, 1'b0, 32'hDEADBEEF, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    endtask

    task automatic test_stall_and_select();
        do_txn(4'b0001, 4'b0001, 1'b1, 32'h1234_5678, 3, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        do_txn(4'b1010, 4'b1010, 1'b0, 32'hA5A5_0001, 1, 2, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        do_txn(4'b0110, 4'b0100, 1'b1, 32'h0BAD_F00D, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        do_txn(4'b1000, 4'b1000, 1'b0, 32'hFFFF_FFFF, 2, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    endtask

    task automatic test_grant_while_busy();
        do_txn(4'b0001, 4'b0011, 1'b0, 32'h0000_1111, 3, 2, 4'b0010, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy !== 1'b0 || mem_valid !== 1'b0) begin
                errors++;
                $display("FAIL dropped_grant got busy=%0b v=%0b exp busy=0 v=0", busy, mem_valid);
            end
            tick();
        end
        do_txn(4'b0010, 4'b0010, 1'b1, 32'h0000_2222, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    endtask

    task automatic test_grant_no_req();
        core_req_valid = 4'b0000;
        grant          = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || mem_valid !== 1'b0) begin
                errors++;
                $display("FAIL grant_no_req got busy=%0b v=%0b exp busy=0 v=0", busy, mem_valid);
            end
        end
        grant = 4'b0000;
    endtask

    task automatic test_back_to_back();
        do_txn(4'b0001, 4'b0001, 1'b0, 32'hCAFE_0001, 0, 0, 4'b0000, 4'b1000, 4'b1000, 1'b0);
        do_txn(4'b1000, 4'b1000, 1'b0, 32'hCAFE_0002, 1, 1, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    endtask

    task automatic test_reset_mid();
        randomize_payloads();
        core_req_valid = 4'b0100;
        grant          = 4'b0100;
        tick();
        grant     = 4'b0000;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait got busy=%0b v=%0b exp busy=1 v=0", busy, mem_valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n          = 1'b1;
        core_req_valid = 4'b0000;
        checks++;
        if (busy !== 1'b0 || core_ack !== 4'b0000 || core_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got busy=%0b ack=%b rd=%h a=%h exp 0/0000/0/0",
                     busy, core_ack, core_rdata, mem_addr);
        end
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h5555_AAAA;
        tick();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy !== 1'b0 || core_ack !== 4'b0000 || core_rdata !== 32'h0) begin
                errors++;
                $display("FAIL late_rsp got busy=%0b ack=%b rd=%h exp 0/0000/0", busy, core_ack, core_rdata);
            end
            tick();
        end
    endtask

    task automatic test_single_core_write();
        rsp_t r;
        s_addr  = 32'h0000_0ABC;
        s_wdata = 32'h7777_8888;
        s_we    = 1'b1;
        s_req   = 1'b1;
        s_grant = 1'b1;
        tick();
        s_grant = 1'b0;
        s_ready = 1'b1;
        checks++;
        if (s_mem_valid !== 1'b1 || s_mem_we !== 1'b1 || s_mem_addr !== 32'h0000_0ABC ||
            s_mem_wdata !== 32'h7777_8888) begin
            errors++;
            $display("FAIL single_issue got v=%0b w=%0b a=%h d=%h exp 1/1/00000abc/77778888",
                     s_mem_valid, s_mem_we, s_mem_addr, s_mem_wdata);
        end
        tick();
        s_ready  = 1'b0;
        s_rsp    = 1'b1;
        s_mrdata = 32'h0000_0001;
        exp_q.push_back('{4'b0001, 32'h0000_0001});
        tick();
        s_rsp = 1'b0;
        s_req = 1'b0;
        r = exp_q.pop_front();
        checks++;
        if ({3'b000, s_ack} !== r.ack || s_rdata !== r.rdata) begin
            errors++;
            $display("FAIL single_ack got ack=%b rd=%h exp ack=%b rd=%h", s_ack, s_rdata, r.ack[0], r.rdata);
        end
        tick();
        checks++;
        if (s_ack !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after got ack=%b busy=%0b exp 0/0", s_ack, s_busy);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        grant          = '0;
        core_req_valid = '0;
        core_addr      = '0;
        core_wdata     = '0;
        core_we        = '0;
        mem_ready      = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rdata      = '0;
        s_grant        = '0;
        s_req          = '0;
        s_addr         = '0;
        s_wdata        = '0;
        s_we           = '0;
        s_ready        = 1'b0;
        s_rsp          = 1'b0;
        s_mrdata       = '0;
        #1;
        test_reset();
        test_basic_read();
        test_stall_and_select();
        test_grant_while_busy();
        test_grant_no_req();
        test_back_to_back();
        test_reset_mid();
        test_single_core_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/core_mem_mux.md
CORE_MEM_MUX -- requirements
Module: core_mem_mux

Interface
REQ-001 Parameter NUM_CORES, default 1, number of requesting cores; matches the upstream round-robin arbiter.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 grant  input  NUM_CORES  grant vector from the arbiter, normally one-hot or zero.
REQ-007 core_req_valid  input  NUM_CORES  per-core request pending; held high by the core until its ack.
REQ-008 core_addr  input  NUM_CORES*ADDR_W  core i at [i*ADDR_W +: ADDR_W].
REQ-009 core_wdata  input  NUM_CORES*DATA_W  core i at [i*DATA_W +: DATA_W].
REQ-010 core_we  input  NUM_CORES  per-core write enable (1=write, 0=read).
REQ-011 core_ack  output  NUM_CORES  registered one-cycle completion pulse to the owning core.
REQ-012 core_rdata  output  DATA_W  shared read-data bus; valid in the core_ack cycle.
REQ-013 mem_valid, mem_addr, mem_wdata, mem_we  output  1/ADDR_W/DATA_W/1  registered request to shared memory.
REQ-014 mem_ready  input  1  memory accepts request when mem_valid && mem_ready.
REQ-015 mem_rsp_valid, mem_rdata  input  1/DATA_W  memory response, one cycle, for reads and writes.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT; exactly one transaction outstanding at a time.
REQ-018 IDLE: if (grant & core_req_valid) != 0, latch owner index, addr, wdata, we of the lowest set bit of that vector and go to ISSUE; otherwise stay.
REQ-019 Grant bits without the matching core_req_valid SHALL be ignored.
REQ-020 Grants arriving in ISSUE or WAIT SHALL be dropped without side effects; the core keeps requesting and is regranted later.
REQ-021 ISSUE: mem_valid=1 with latched payload held stable until mem_valid && mem_ready; on handshake, next state WAIT and mem_valid=0 the following cycle.
REQ-022 mem_rsp_valid SHALL be sampled only in WAIT; responses in IDLE/ISSUE are ignored.
REQ-023 WAIT: on mem_rsp_valid, next cycle core_ack[owner]=1 for one cycle, core_rdata=mem_rdata, state IDLE.
REQ-024 Latency: grant sampled at cycle N -> mem_valid high at N+1; handshake at M -> WAIT at M+1; response at K -> core_ack and IDLE at K+1; a new grant in cycle K+1 SHALL be accepted.
REQ-025 core_rdata SHALL hold its value between acks; write responses also drive core_rdata from mem_rdata.
REQ-026 At most one core_ack bit high in any cycle; core_ack never high while mem_valid is high.
REQ-027 Owner index width SHALL be max(1, clog2(NUM_CORES)); NUM_CORES=1 SHALL work with owner fixed at 0.

Reset
REQ-028 rst_n low at a rising edge: state IDLE, mem_valid=0, core_ack=0, busy=0, core_rdata=0, latched addr/wdata/we/owner=0.
REQ-029 Reset mid-transaction SHALL abandon it: no ack is generated and any later mem_rsp_valid is ignored.

Verification
REQ-030 NUM_CORES=4, req=4'b0100, grant=4'b0100 at N, mem_ready=1, rsp at N+3 with rdata=0xDEADBEEF -> mem_valid at N+1 with core 2 addr; core_ack=4'b0100 and core_rdata=0xDEADBEEF at N+4.
REQ-031 mem_ready low 3 cycles in ISSUE -> mem_valid/mem_addr/mem_wdata/mem_we stable all 3 cycles; single handshake.
REQ-032 grant=4'b0010 while busy -> no capture, no change to mem_* or owner; core 1 is served only after a later grant in IDLE.
REQ-033 grant=4'b0001 with core_req_valid=4'b0000 -> stays IDLE, busy=0, mem_valid=0.
REQ-034 rst_n low during WAIT, then mem_rsp_valid=1 -> core_ack stays 0, state IDLE, busy=0.
REQ-035 NUM_CORES=1, write with core_we=1 -> mem_we=1; core_ack=1'b1 one cycle after response.
